// File: rtl/prbs21_checker.sv
`default_nettype none
// ============================================================================
// Module      : prbs21_checker
// Description : Serial PRBS21 (x^21 + x^19 + 1) receive-side checker.
//               Self-seeds from the incoming stream (SEED), confirms the
//               seed against 21 predicted bits (VERIFY), then checks every
//               bit against a free-running local reference (CHECK).
//               Reports lock, per-bit error pulses, saturating error/bit
//               counts and a sticky loss-of-lock flag.
// Options     : PRBS_CHK_RELOCK_EN - when defined, a loss of lock drops the
//               checker back to SEED so it relocks automatically; when
//               undefined, a loss of lock only raises lol_o.
// Revision    : 1.0 - initial release
// ============================================================================
module prbs21_checker #(
  parameter int CNT_W      = 48,
  parameter int WIN        = 64,
  parameter int LOL_THRESH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             data_i,
  input  logic             clear_i,
  output logic             lock_o,
  output logic             err_o,
  output logic             lol_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] bit_cnt_o
);

  // Window counter runs 0..WIN-1; window error count never rests above
  // LOL_THRESH-1 because reaching the threshold clears it.
  localparam int c_win_w = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int c_we_w  = (LOL_THRESH > 0) ? $clog2(LOL_THRESH + 1) : 1;

  localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WIN - 1);
  localparam logic [c_we_w-1:0]  c_thresh   = c_we_w'(LOL_THRESH);
  localparam logic [CNT_W-1:0]   c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [4:0]         c_sr_last  = 5'd20;

  localparam logic [1:0] c_st_seed   = 2'd0;
  localparam logic [1:0] c_st_verify = 2'd1;
  localparam logic [1:0] c_st_check  = 2'd2;

  // State and datapath flops
  logic [1:0]         state_q,   state_d;
  logic [20:0]        sr_q,      sr_d;
  logic [4:0]         cnt_q,     cnt_d;
  logic [c_win_w-1:0] win_cnt_q, win_cnt_d;
  logic [c_we_w-1:0]  win_err_q, win_err_d;

  // Output flops
  logic               lock_q,    lock_d;
  logic               err_q,     err_d;
  logic               lol_q,     lol_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

  // Combinational helpers
  logic               w_pred;
  logic               w_chk;
  logic               w_mis;
  logic [c_we_w-1:0]  w_win_err_nxt;
  logic               w_lol_hit;

  // Reference prediction and the per-bit mismatch while checking
  always_comb begin
    w_pred = sr_q[20] ^ sr_q[18];
    w_chk  = en_i && (state_q == c_st_check);
    w_mis  = w_chk && (data_i ^ w_pred);
  end

  // Loss-of-lock window: counts checked bits and errors within the window
  always_comb begin
    win_cnt_d     = win_cnt_q;
    win_err_d     = win_err_q;
    w_win_err_nxt = win_err_q + c_we_w'(w_mis);
    w_lol_hit     = w_mis && (w_win_err_nxt >= c_thresh);
    if (w_chk) begin
      if (w_lol_hit || (win_cnt_q == c_win_last)) begin
        // Threshold hit or window wrap: start a fresh window.
        win_cnt_d = '0;
        win_err_d = '0;
      end else begin
        win_cnt_d = win_cnt_q + c_win_w'(1);
        win_err_d = w_win_err_nxt;
      end
    end
  end

  // Seed / verify / check sequencing and reference shift register
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    if (en_i) begin
      case (state_q)
        c_st_seed: begin
          sr_d = {sr_q[19:0], data_i};
          if (cnt_q == c_sr_last) begin
            // A full register of zeros is the LFSR lock-up state; keep seeding.
            cnt_d = '0;
            if (sr_d != '0) begin
              state_d = c_st_verify;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        c_st_verify: begin
          sr_d = {sr_q[19:0], data_i};
          if (data_i != w_pred) begin
            state_d = c_st_seed;
            cnt_d   = '0;
          end else if (cnt_q == c_sr_last) begin
            state_d = c_st_check;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        c_st_check: begin
          // Shift the prediction, not the input, so a flipped input bit
          // cannot corrupt the reference.
          sr_d = {sr_q[19:0], w_pred};
`ifdef PRBS_CHK_RELOCK_EN
          if (w_lol_hit) begin
            state_d = c_st_seed;
            cnt_d   = '0;
          end
`endif
        end
        default: begin
          state_d = c_st_seed;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Registered outputs: error pulse, saturating counters, sticky LOL, lock
  always_comb begin
    err_d     = w_mis;
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;
    lol_d     = lol_q || w_lol_hit;
    if (w_chk) begin
      if (bit_cnt_q != c_cnt_max) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
      if (w_mis && (err_cnt_q != c_cnt_max)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
    // Clear takes priority over any same-cycle increment or LOL set.
    if (clear_i) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
      lol_d     = 1'b0;
    end
    lock_d = (state_d == c_st_check);
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= c_st_seed;
      sr_q      <= '0;
      cnt_q     <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
    end
  end

  // Output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
      lol_q     <= 1'b0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      lock_q    <= lock_d;
      err_q     <= err_d;
      lol_q     <= lol_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign lock_o    = lock_q;
  assign err_o     = err_q;
  assign lol_o     = lol_q;
  assign err_cnt_o = err_cnt_q;
  assign bit_cnt_o = bit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs21_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_prbs21_checker
// Description : Directed self-checking bench for prbs21_checker. A local
//               PRBS21 generator supplies the stream; expected values are
//               hand-derived bit positions and counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs21_checker;

  localparam int CNT_W = 48;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             en_i;
  logic             data_i;
  logic             clear_i;
  logic             lock_o;
  logic             err_o;
  logic             lol_o;
  logic [CNT_W-1:0] err_cnt_o;
  logic [CNT_W-1:0] bit_cnt_o;

  int total = 0;
  int bad   = 0;

  logic [20:0] g;

  prbs21_checker #(
    .CNT_W      (CNT_W),
    .WIN        (64),
    .LOL_THRESH (8)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (en_i),
    .data_i    (data_i),
    .clear_i   (clear_i),
    .lock_o    (lock_o),
    .err_o     (err_o),
    .lol_o     (lol_o),
    .err_cnt_o (err_cnt_o),
    .bit_cnt_o (bit_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference PRBS21 generator: x^21 + x^19 + 1
  task automatic next_bit(output logic b);
    b = g[20] ^ g[18];
    g = {g[19:0], b};
  endtask

  // Apply one cycle of inputs, return 1 time unit after the sampling edge
  task automatic step(input logic e, input logic d, input logic c);
    en_i    = e;
    data_i  = d;
    clear_i = c;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni  = 1'b0;
    en_i    = 1'b0;
    data_i  = 1'b0;
    clear_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    g      = 21'h01ABCD;
  endtask

  task automatic test_reset();
    rst_ni  = 1'b0;
    en_i    = 1'b1;
    data_i  = 1'b1;
    clear_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    total++; if (lock_o !== 1'b0) begin bad++; $display("FAIL reset_lock: got %b want 0", lock_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_o); end
    total++; if (lol_o !== 1'b0) begin bad++; $display("FAIL reset_lol: got %b want 0", lol_o); end
    total++; if (err_cnt_o !== '0) begin bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt_o); end
    total++; if (bit_cnt_o !== '0) begin bad++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_clean();
    logic b;
    int   pulses;
    pulses = 0;
    do_reset();
    for (int i = 1; i <= 1000; i++) begin
      next_bit(b);
      step(1'b1, b, 1'b0);
      if (err_o === 1'b1) pulses++;
      if (i == 41) begin
        total++; if (lock_o !== 1'b0) begin bad++; $display("FAIL clean_lock41: got %b want 0", lock_o); end
      end
      if (i == 42) begin
        total++; if (lock_o !== 1'b1) begin bad++; $display("FAIL clean_lock42: got %b want 1", lock_o); end
        total++; if (bit_cnt_o !== 48'd0) begin bad++; $display("FAIL clean_bitcnt42: got %0d want 0", bit_cnt_o); end
      end
      if (i == 43) begin
        total++; if (bit_cnt_o !== 48'd1) begin bad++; $display("FAIL clean_bitcnt43: got %0d want 1", bit_cnt_o); end
      end
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL clean_err_pulses: got %0d want 0", pulses); end
    total++; if (err_cnt_o !== 48'd0) begin bad++; $display("FAIL clean_err_cnt: got %0d want 0", err_cnt_o); end
    total++; if (bit_cnt_o !== 48'd958) begin bad++; $display("FAIL clean_bit_cnt: got %0d want 958", bit_cnt_o); end
    total++; if (lol_o !== 1'b0) begin bad++; $display("FAIL clean_lol: got %b want 0", lol_o); end
  endtask

  task automatic test_single_error();
    logic b;
    int   pulses;
    int   at_bit;
    pulses = 0;
    at_bit = -1;
    do_reset();
    for (int i = 1; i <= 1000; i++) begin
      next_bit(b);
      if (i == 500) b = ~b;
      step(1'b1, b, 1'b0);
      if (err_o === 1'b1) begin
        pulses++;
        at_bit = i;
      end
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL single_pulses: got %0d want 1", pulses); end
    total++; if (at_bit != 500) begin bad++; $display("FAIL single_pulse_pos: got %0d want 500", at_bit); end
    total++; if (err_cnt_o !== 48'd1) begin bad++; $display("FAIL single_err_cnt: got %0d want 1", err_cnt_o); end
    total++; if (lock_o !== 1'b1) begin bad++; $display("FAIL single_lock: got %b want 1", lock_o); end
    total++; if (bit_cnt_o !== 48'd958) begin bad++; $display("FAIL single_bit_cnt: got %0d want 958", bit_cnt_o); end
  endtask

  // Bits 50..57 inverted: all inside the first window (checked bits 43..106)
  task automatic test_burst();
    logic b;
    do_reset();
    for (int i = 1; i <= 99; i++) begin
      next_bit(b);
      if (i >= 50 && i <= 57) b = ~b;
      step(1'b1, b, 1'b0);
      if (i == 56) begin
        total++; if (lol_o !== 1'b0) begin bad++; $display("FAIL burst_lol7: got %b want 0", lol_o); end
      end
      if (i == 57) begin
        total++; if (lol_o !== 1'b1) begin bad++; $display("FAIL burst_lol8: got %b want 1", lol_o); end
        total++; if (err_cnt_o !== 48'd8) begin bad++; $display("FAIL burst_err_cnt: got %0d want 8", err_cnt_o); end
        total++; if (bit_cnt_o !== 48'd15) begin bad++; $display("FAIL burst_bit_cnt: got %0d want 15", bit_cnt_o); end
`ifdef PRBS_CHK_RELOCK_EN
        total++; if (lock_o !== 1'b0) begin bad++; $display("FAIL burst_lock_drop: got %b want 0", lock_o); end
`else
        total++; if (lock_o !== 1'b1) begin bad++; $display("FAIL burst_lock_hold: got %b want 1", lock_o); end
`endif
      end
`ifdef PRBS_CHK_RELOCK_EN
      if (i == 98) begin
        total++; if (lock_o !== 1'b0) begin bad++; $display("FAIL burst_relock98: got %b want 0", lock_o); end
      end
`endif
    end
    total++; if (lock_o !== 1'b1) begin bad++; $display("FAIL burst_lock99: got %b want 1", lock_o); end
    total++; if (lol_o !== 1'b1) begin bad++; $display("FAIL burst_lol_sticky: got %b want 1", lol_o); end
    total++; if (err_cnt_o !== 48'd8) begin bad++; $display("FAIL burst_err_cnt99: got %0d want 8", err_cnt_o); end
`ifdef PRBS_CHK_RELOCK_EN
    total++; if (bit_cnt_o !== 48'd15) begin bad++; $display("FAIL burst_bit_cnt99: got %0d want 15", bit_cnt_o); end
`else
    total++; if (bit_cnt_o !== 48'd57) begin bad++; $display("FAIL burst_bit_cnt99: got %0d want 57", bit_cnt_o); end
`endif
  endtask

  task automatic test_all_zero();
    int seen_lock;
    seen_lock = 0;
    do_reset();
    for (int i = 1; i <= 200; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (lock_o !== 1'b0) seen_lock++;
    end
    total++; if (seen_lock != 0) begin bad++; $display("FAIL zero_lock: got %0d locked cycles want 0", seen_lock); end
    total++; if (err_cnt_o !== 48'd0) begin bad++; $display("FAIL zero_err_cnt: got %0d want 0", err_cnt_o); end
    total++; if (bit_cnt_o !== 48'd0) begin bad++; $display("FAIL zero_bit_cnt: got %0d want 0", bit_cnt_o); end
  endtask

  task automatic test_clear_collision();
    logic b;
    do_reset();
    for (int i = 1; i <= 60; i++) begin
      next_bit(b);
      step(1'b1, b, 1'b0);
    end
    next_bit(b);
    step(1'b1, ~b, 1'b1);
    total++; if (err_cnt_o !== 48'd0) begin bad++; $display("FAIL clear_err_cnt: got %0d want 0", err_cnt_o); end
    total++; if (bit_cnt_o !== 48'd0) begin bad++; $display("FAIL clear_bit_cnt: got %0d want 0", bit_cnt_o); end
    for (int i = 62; i <= 70; i++) begin
      next_bit(b);
      if (i == 70) b = ~b;
      step(1'b1, b, 1'b0);
    end
    total++; if (err_cnt_o !== 48'd1) begin bad++; $display("FAIL clear_later_err_cnt: got %0d want 1", err_cnt_o); end
    total++; if (bit_cnt_o !== 48'd9) begin bad++; $display("FAIL clear_later_bit_cnt: got %0d want 9", bit_cnt_o); end
  endtask

  task automatic test_gap_reset();
    logic b;
    int   gap_err;
    int   gap_cnt;
    gap_err = 0;
    gap_cnt = 0;
    do_reset();
    for (int i = 1; i <= 80; i++) begin
      next_bit(b);
      step(1'b1, b, 1'b0);
    end
    total++; if (bit_cnt_o !== 48'd38) begin bad++; $display("FAIL gap_pre_bit_cnt: got %0d want 38", bit_cnt_o); end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, k[0], 1'b0);
      if (err_o !== 1'b0) gap_err++;
      if (bit_cnt_o !== 48'd38 || err_cnt_o !== 48'd0 || lock_o !== 1'b1) gap_cnt++;
    end
    total++; if (gap_err != 0) begin bad++; $display("FAIL gap_err_o: got %0d pulses want 0", gap_err); end
    total++; if (gap_cnt != 0) begin bad++; $display("FAIL gap_frozen: got %0d changed cycles want 0", gap_cnt); end
    for (int i = 81; i <= 90; i++) begin
      next_bit(b);
      step(1'b1, b, 1'b0);
    end
    total++; if (bit_cnt_o !== 48'd48) begin bad++; $display("FAIL gap_post_bit_cnt: got %0d want 48", bit_cnt_o); end
    total++; if (err_cnt_o !== 48'd0) begin bad++; $display("FAIL gap_post_err_cnt: got %0d want 0", err_cnt_o); end
    // Asynchronous reset: outputs must clear before any clock edge
    rst_ni = 1'b0;
    #2;
    total++; if (lock_o !== 1'b0) begin bad++; $display("FAIL async_rst_lock: got %b want 0", lock_o); end
    total++; if (bit_cnt_o !== 48'd0) begin bad++; $display("FAIL async_rst_bit_cnt: got %0d want 0", bit_cnt_o); end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int i = 1; i <= 42; i++) begin
      next_bit(b);
      step(1'b1, b, 1'b0);
      if (i == 41) begin
        total++; if (lock_o !== 1'b0) begin bad++; $display("FAIL relock41: got %b want 0", lock_o); end
      end
    end
    total++; if (lock_o !== 1'b1) begin bad++; $display("FAIL relock42: got %b want 1", lock_o); end
    total++; if (bit_cnt_o !== 48'd0) begin bad++; $display("FAIL relock_bit_cnt: got %0d want 0", bit_cnt_o); end
  endtask

  initial begin
    rst_ni  = 1'b0;
    en_i    = 1'b0;
    data_i  = 1'b0;
    clear_i = 1'b0;
    g       = 21'h01ABCD;
    test_reset();
    test_clean();
    test_single_error();
    test_burst();
    test_all_zero();
    test_clear_collision();
    test_gap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
